// File: rtl/burst_write_m.sv
// burst_write_m: burst bus-write master for the extended DLX memory interface.
// Issues 1..BURST_MAX write beats per request over the AS_N/WR_N/ACK_N
// handshake, generating addresses internally and popping data from a source.
// Optional build macro: WRITE_TIMEOUT_EN (bounded ACK wait, sticky ERR flag).
//
// state        | meaning
// IDLE     (0) | waiting for STEP_EN
// STORE    (1) | beat launched
// WAIT4ACK (2) | strobes held until ACK_N is sampled low
// NEXT     (3) | strobes released, address step, data pop
// TERM     (4) | burst finished, DONE pulse
//
// Strobes and pulses are registered decodes of the current state, so each
// appears on the bus one cycle after the state that produces it. STOP_N is
// the only combinational output so the core is released in the same cycle
// ACK_N falls.

module burst_write_m #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 8,
  parameter int LEN_W     = $clog2(BURST_MAX + 1),
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              STEP_EN,
  input  logic [LEN_W-1:0]  BURST_LEN,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              ACK_N,
  output logic              AS_N,
  output logic              WR_N,
  output logic [ADDR_W-1:0] ADDR_O,
  output logic [DATA_W-1:0] DOUT,
  output logic              WDATA_RD,
  output logic              ADDR_CNT_CE,
  output logic              STOP_N,
  output logic              IN_INIT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        CURR_STATE_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STORE    = 3'd1,
    S_WAIT4ACK = 3'd2,
    S_NEXT     = 3'd3,
    S_TERM     = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(BURST_MAX);

  // Elaboration-time sanity check on the parameter set.
  if (BURST_MAX < 1 || TIMEOUT < 1) begin : g_param_check
    $error("burst_write_m: BURST_MAX and TIMEOUT must both be at least 1");
  end

  state_t            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              as_n_q;
  logic              wr_n_q;
  logic              in_init_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_q;
  logic              ce_q;
  logic              err_q;

  logic [LEN_W-1:0]  len_sat_d;
  logic [LEN_W-1:0]  cnt_dec_d;
  logic [ADDR_W-1:0] addr_inc_d;

`ifdef WRITE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  // Oversized requests are clamped to the burst limit.
  assign len_sat_d  = (BURST_LEN > MaxLen) ? MaxLen : BURST_LEN;
  assign cnt_dec_d  = cnt_q - LEN_W'(1);
  assign addr_inc_d = addr_q + ADDR_W'(1);

  // Burst sequencer: state, datapath registers and registered Moore outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      as_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      in_init_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      ce_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef WRITE_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      as_n_q    <= !(state_q == S_STORE || state_q == S_WAIT4ACK);
      wr_n_q    <= !(state_q == S_STORE || state_q == S_WAIT4ACK);
      in_init_q <= (state_q == S_IDLE) || (state_q == S_TERM);
      busy_q    <= (state_q != S_IDLE);
      done_q    <= (state_q == S_TERM);
      rd_q      <= (state_q == S_NEXT);
      ce_q      <= (state_q == S_NEXT);

      case (state_q)
        S_IDLE: begin
          if (STEP_EN) begin
            err_q <= 1'b0;
            if (BURST_LEN != '0) begin
              cnt_q   <= len_sat_d;
              addr_q  <= START_ADDR;
              dout_q  <= WDATA;
              state_q <= S_STORE;
            end else begin
              state_q <= S_TERM;
            end
          end
        end

        S_STORE: begin
`ifdef WRITE_TIMEOUT_EN
          wait_q  <= '0;
`endif
          state_q <= S_WAIT4ACK;
        end

        S_WAIT4ACK: begin
          if (!ACK_N) begin
            state_q <= S_NEXT;
`ifdef WRITE_TIMEOUT_EN
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            // Abandon the rest of the burst; this beat is not counted.
            err_q   <= 1'b1;
            state_q <= S_TERM;
          end else begin
            wait_q  <= wait_q + WAIT_W'(1);
`endif
          end
        end

        S_NEXT: begin
          cnt_q  <= cnt_dec_d;
          addr_q <= addr_inc_d;
          if (cnt_dec_d != '0) begin
            // The source has already advanced to the next word here.
            dout_q  <= WDATA;
            state_q <= S_STORE;
          end else begin
            state_q <= S_TERM;
          end
        end

        S_TERM: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign STOP_N       = !((state_q == S_WAIT4ACK) && ACK_N);
  assign AS_N         = as_n_q;
  assign WR_N         = wr_n_q;
  assign ADDR_O       = addr_q;
  assign DOUT         = dout_q;
  assign WDATA_RD     = rd_q;
  assign ADDR_CNT_CE  = ce_q;
  assign IN_INIT      = in_init_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign CURR_STATE_o = state_q;

endmodule

// File: tb/tb_burst_write_m.sv
// Self-checking bench for burst_write_m: directed bursts against a simple
// slave that acknowledges a fixed number of cycles after AS_N falls.
module tb_burst_write_m;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 8;
  localparam int LEN_W     = 4;
  localparam int TIMEOUT   = 255;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              STEP_EN = 1'b0;
  logic [LEN_W-1:0]  BURST_LEN = '0;
  logic [ADDR_W-1:0] START_ADDR = '0;
  logic [DATA_W-1:0] WDATA = '0;
  logic              ACK_N = 1'b1;
  logic              AS_N, WR_N, WDATA_RD, ADDR_CNT_CE, STOP_N;
  logic              IN_INIT, BUSY, DONE, ERR;
  logic [ADDR_W-1:0] ADDR_O;
  logic [DATA_W-1:0] DOUT;
  logic [2:0]        CURR_STATE_o;

  burst_write_m #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX),
    .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .STEP_EN(STEP_EN), .BURST_LEN(BURST_LEN),
    .START_ADDR(START_ADDR), .WDATA(WDATA), .ACK_N(ACK_N), .AS_N(AS_N),
    .WR_N(WR_N), .ADDR_O(ADDR_O), .DOUT(DOUT), .WDATA_RD(WDATA_RD),
    .ADDR_CNT_CE(ADDR_CNT_CE), .STOP_N(STOP_N), .IN_INIT(IN_INIT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CURR_STATE_o(CURR_STATE_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // per-burst observations
  int cyc = 0, beats = 0, ce_cnt = 0, rd_cnt = 0, stop_cnt = 0;
  int done_cnt = 0, done_cyc = -1, busy_cnt = 0, init_low_cnt = 0;
  int first_low_cyc = -1, win_len = 0, win_min = 1000, win_max = 0;
  int stable_err = 0, wr_err = 0;
  logic [ADDR_W-1:0] addr_log [16];
  logic [DATA_W-1:0] dout_log [16];

  // slave / source model state
  logic              prev_as_n = 1'b1;
  logic              ack_prev = 1'b0;
  int                k = 0;
  int                ack_delay = 0;
  int                widx = 0;
  logic [DATA_W-1:0] wbase = '0;

  // One clock: observe registered outputs, advance source, drive slave ACK,
  // then observe the combinational STOP_N.
  task automatic step();
    @(posedge CLK); #1;
    cyc++;
    if (ADDR_CNT_CE) ce_cnt++;
    if (WDATA_RD) rd_cnt++;
    if (DONE) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
    if (BUSY) busy_cnt++;
    if (!IN_INIT) init_low_cnt++;
    if (WR_N !== AS_N) wr_err++;
    if (!AS_N) begin
      if (prev_as_n) begin
        if (beats < 16) begin
          addr_log[beats] = ADDR_O;
          dout_log[beats] = DOUT;
        end
        if (beats == 0) first_low_cyc = cyc;
        beats++;
        win_len = 0;
      end else if (beats > 0 && beats <= 16) begin
        if (ADDR_O !== addr_log[beats-1] || DOUT !== dout_log[beats-1]) stable_err++;
      end
      win_len++;
      k++;
    end else begin
      if (!prev_as_n) begin
        if (win_len < win_min) win_min = win_len;
        if (win_len > win_max) win_max = win_len;
      end
      k = 0;
    end
    prev_as_n = AS_N;
    if (ack_prev) begin
      widx++;
      WDATA = wbase + 32'(widx);
    end
    ack_prev = (!AS_N && k == ack_delay + 1);
    ACK_N = !ack_prev;
    #1;
    if (!STOP_N) stop_cnt++;
  endtask

  task automatic start_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n,
                             input logic [DATA_W-1:0] base, input int d, input bit hold);
    cyc = -1; beats = 0; ce_cnt = 0; rd_cnt = 0; stop_cnt = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; init_low_cnt = 0;
    first_low_cyc = -1; win_len = 0; win_min = 1000; win_max = 0;
    stable_err = 0; wr_err = 0;
    prev_as_n = 1'b1; ack_prev = 1'b0; k = 0; ack_delay = d; widx = 0;
    wbase = base; WDATA = base; ACK_N = 1'b1;
    START_ADDR = a; BURST_LEN = n; STEP_EN = 1'b1;
    step();
    if (!hold) STEP_EN = 1'b0;
    START_ADDR = ~a;
    BURST_LEN = '1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    STEP_EN = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_wait: no DONE within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #22;
    checks++;
    if ({AS_N, WR_N, IN_INIT, STOP_N, WDATA_RD, ADDR_CNT_CE, DONE, ERR, BUSY} !== 9'b111100000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 111100000",
               {AS_N, WR_N, IN_INIT, STOP_N, WDATA_RD, ADDR_CNT_CE, DONE, ERR, BUSY});
    end
    checks++;
    if (ADDR_O !== 16'h0000 || DOUT !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got addr %h dout %h expected 0000 00000000", ADDR_O, DOUT);
    end
    checks++;
    if (CURR_STATE_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d expected 0", CURR_STATE_o);
    end
    RESET_N = 1'b1;
    step();
    step();
  endtask

  task automatic test_single_beat();
    start_burst(16'h0010, 4'd1, 32'hDEADBEEF, 0, 1'b0);
    wait_done(20);
    step();
    step();
    checks++;
    if (beats !== 1 || addr_log[0] !== 16'h0010 || dout_log[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_beat: got beats %0d addr %h dout %h expected 1 0010 deadbeef",
               beats, addr_log[0], dout_log[0]);
    end
    checks++;
    if (win_min !== 2 || win_max !== 2 || first_low_cyc !== 1) begin
      failures++;
      $display("FAIL single_window: got len %0d..%0d first %0d expected 2..2 first 1",
               win_min, win_max, first_low_cyc);
    end
    checks++;
    if (done_cyc !== 4 || done_cnt !== 1) begin
      failures++;
      $display("FAIL single_done: got cycle %0d count %0d expected 4 1", done_cyc, done_cnt);
    end
    checks++;
    if (ADDR_O !== 16'h0011) begin
      failures++;
      $display("FAIL single_addr_after: got %h expected 0011", ADDR_O);
    end
    checks++;
    if (ce_cnt !== 1 || rd_cnt !== 1 || stop_cnt !== 0) begin
      failures++;
      $display("FAIL single_pulses: got ce %0d rd %0d stop %0d expected 1 1 0", ce_cnt, rd_cnt, stop_cnt);
    end
    checks++;
    if (busy_cnt !== 4 || init_low_cnt !== 3 || wr_err !== 0 || stable_err !== 0) begin
      failures++;
      $display("FAIL single_status: got busy %0d init_low %0d wr_err %0d stable_err %0d expected 4 3 0 0",
               busy_cnt, init_low_cnt, wr_err, stable_err);
    end
  endtask

  task automatic test_burst_ack_delay();
    start_burst(16'h0100, 4'd4, 32'hA0000000, 2, 1'b0);
    wait_done(60);
    step();
    step();
    checks++;
    if (beats !== 4) begin
      failures++;
      $display("FAIL burst4_beats: got %0d expected 4", beats);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_log[i] !== 16'h0100 + 16'(i) || dout_log[i] !== 32'hA0000000 + 32'(i)) begin
        failures++;
        $display("FAIL burst4_beat%0d: got addr %h dout %h expected %h %h", i,
                 addr_log[i], dout_log[i], 16'h0100 + 16'(i), 32'hA0000000 + 32'(i));
      end
    end
    checks++;
    if (ce_cnt !== 4 || rd_cnt !== 4 || stop_cnt !== 8) begin
      failures++;
      $display("FAIL burst4_pulses: got ce %0d rd %0d stop %0d expected 4 4 8", ce_cnt, rd_cnt, stop_cnt);
    end
    checks++;
    if (win_min !== 4 || win_max !== 4 || done_cyc !== 21 || ADDR_O !== 16'h0104) begin
      failures++;
      $display("FAIL burst4_timing: got win %0d..%0d done %0d addr %h expected 4..4 21 0104",
               win_min, win_max, done_cyc, ADDR_O);
    end
    checks++;
    if (ERR !== 1'b0 || stable_err !== 0 || wr_err !== 0) begin
      failures++;
      $display("FAIL burst4_clean: got err %b stable_err %0d wr_err %0d expected 0 0 0", ERR, stable_err, wr_err);
    end
  endtask

  task automatic test_zero_len();
    start_burst(16'h0200, 4'd0, 32'h11111111, 0, 1'b0);
    wait_done(10);
    step(); step(); step();
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1 || beats !== 0 || busy_cnt !== 1 || ce_cnt !== 0) begin
      failures++;
      $display("FAIL zero_len: got done %0d/%0d beats %0d busy %0d ce %0d expected 1/1 0 1 0",
               done_cyc, done_cnt, beats, busy_cnt, ce_cnt);
    end
    checks++;
    if (ADDR_O !== 16'h0104) begin
      failures++;
      $display("FAIL zero_len_addr: got %h expected 0104", ADDR_O);
    end
  endtask

  task automatic test_len_clamp();
    start_burst(16'h0300, 4'd15, 32'h30000000, 0, 1'b0);
    wait_done(60);
    step();
    checks++;
    if (beats !== 8 || ce_cnt !== 8 || rd_cnt !== 8 || done_cyc !== 25 || ADDR_O !== 16'h0308) begin
      failures++;
      $display("FAIL len_clamp: got beats %0d ce %0d rd %0d done %0d addr %h expected 8 8 8 25 0308",
               beats, ce_cnt, rd_cnt, done_cyc, ADDR_O);
    end
  endtask

  task automatic test_addr_wrap();
    start_burst(16'hFFFE, 4'd3, 32'h55550000, 1, 1'b0);
    wait_done(40);
    step();
    checks++;
    if (beats !== 3 || addr_log[0] !== 16'hFFFE || addr_log[1] !== 16'hFFFF || addr_log[2] !== 16'h0000) begin
      failures++;
      $display("FAIL addr_wrap: got beats %0d addrs %h %h %h expected 3 fffe ffff 0000",
               beats, addr_log[0], addr_log[1], addr_log[2]);
    end
    checks++;
    if (ADDR_O !== 16'h0001 || done_cyc !== 13 || stop_cnt !== 3 || dout_log[2] !== 32'h55550002) begin
      failures++;
      $display("FAIL addr_wrap_end: got addr %h done %0d stop %0d dout %h expected 0001 13 3 55550002",
               ADDR_O, done_cyc, stop_cnt, dout_log[2]);
    end
  endtask

  task automatic test_step_hold();
    start_burst(16'h0400, 4'd2, 32'h40000000, 0, 1'b1);
    wait_done(30);
    step();
    checks++;
    if (beats !== 2 || done_cnt !== 1 || done_cyc !== 7 || CURR_STATE_o !== 3'd0) begin
      failures++;
      $display("FAIL step_hold: got beats %0d done %0d@%0d state %0d expected 2 1@7 0",
               beats, done_cnt, done_cyc, CURR_STATE_o);
    end
    start_burst(16'h0500, 4'd1, 32'h50000000, 0, 1'b0);
    checks++;
    if (CURR_STATE_o !== 3'd1) begin
      failures++;
      $display("FAIL back_to_back_accept: got state %0d expected 1", CURR_STATE_o);
    end
    wait_done(20);
    checks++;
    if (beats !== 1 || addr_log[0] !== 16'h0500 || dout_log[0] !== 32'h50000000 || done_cyc !== 4) begin
      failures++;
      $display("FAIL back_to_back: got beats %0d addr %h dout %h done %0d expected 1 0500 50000000 4",
               beats, addr_log[0], dout_log[0], done_cyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    start_burst(16'h0600, 4'd3, 32'h60000000, 3, 1'b0);
    while (!(beats == 2 && k == 1) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (CURR_STATE_o !== 3'd2 || STOP_N !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_setup: got state %0d stop_n %b expected 2 0", CURR_STATE_o, STOP_N);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({AS_N, WR_N, STOP_N, BUSY} !== 4'b1110 || CURR_STATE_o !== 3'd0 || ADDR_O !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid: got as/wr/stop/busy %b state %0d addr %h expected 1110 0 0000",
               {AS_N, WR_N, STOP_N, BUSY}, CURR_STATE_o, ADDR_O);
    end
    #1;
    RESET_N = 1'b1;
    ACK_N = 1'b1;
    done_cnt = 0;
    step();
    step();
    checks++;
    if (done_cnt !== 0 || CURR_STATE_o !== 3'd0 || AS_N !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_after: got done %0d state %0d as_n %b expected 0 0 1",
               done_cnt, CURR_STATE_o, AS_N);
    end
  endtask

`ifdef WRITE_TIMEOUT_EN
  task automatic test_timeout();
    start_burst(16'h0700, 4'd2, 32'h70000000, 100000, 1'b0);
    wait_done(400);
    checks++;
    if (done_cyc !== 257 || ERR !== 1'b1 || ce_cnt !== 0 || rd_cnt !== 0 || stop_cnt !== 255 || beats !== 1) begin
      failures++;
      $display("FAIL timeout: got done %0d err %b ce %0d rd %0d stop %0d beats %0d expected 257 1 0 0 255 1",
               done_cyc, ERR, ce_cnt, rd_cnt, stop_cnt, beats);
    end
    step();
    start_burst(16'h0800, 4'd1, 32'h80000000, 0, 1'b0);
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_clear: got %b expected 0", ERR);
    end
    wait_done(20);
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_burst_ack_delay();
    test_zero_len();
    test_len_clamp();
    test_addr_wrap();
    test_step_hold();
    test_reset_mid_burst();
`ifdef WRITE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
